// File: rtl/reaction_sequencer_if.sv
// Reaction sequencer bundle: the datapath inputs the controller samples
// (start request, debounced button, LFSR value) and the LED/score outputs it
// drives.
//   master : the side that drives start/button/rand_in and watches the results
//   slave  : the sequencer itself
interface reaction_sequencer_if;
    logic        start;
    logic        button;
    logic [9:0]  rand_in;
    logic        led_on;
    logic        busy;
    logic [13:0] rt_ms;
    logic        rt_valid;
    logic        false_start;
    logic        timeout;

    modport master (
        output start, button, rand_in,
        input  led_on, busy, rt_ms, rt_valid, false_start, timeout
    );

    modport slave (
        input  start, button, rand_in,
        output led_on, busy, rt_ms, rt_valid, false_start, timeout
    );
endinterface

// File: rtl/reaction_sequencer.sv
// Reaction-timer controller. A start request samples the free-running LFSR
// once to form a random delay (MIN_DELAY_MS + rand_in ms), counts it down,
// lights the stimulus LED and measures the time to the next button press in
// ms. False starts and timeouts are reported as separate outcomes.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : reaction_sequencer_if.slave
//          in : start, button (debounced, clk-synchronous), rand_in[9:0]
//          out: led_on, busy, rt_ms[13:0], rt_valid, false_start, timeout
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, nothing measured yet; waits for start
// WAIT   | random delay running, LED off; a press here is a false start
// GO     | LED on, ms counter running until press or MAX_RT_MS
// RESULT | outcome held until the next start
module reaction_sequencer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_RT_MS    = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    reaction_sequencer_if.slave  bus
);

    localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [13:0]   MIN_D   = 14'(MIN_DELAY_MS);
    localparam logic [13:0]   MAX_RT  = 14'(MAX_RT_MS);
    localparam logic [13:0]   MAX_M1  = 14'(MAX_RT_MS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, GO, RESULT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   delay_q, delay_d;
    logic [13:0]   ms_q, ms_d;
    logic [13:0]   rt_ms_q, rt_ms_d;
    logic          button_q;
    logic          led_q, led_d;
    logic          rv_q, rv_d;
    logic          fs_q, fs_d;
    logic          to_q, to_d;

    logic press;
    logic tick;

    // Edge detect against the previous cycle's level, so a button already
    // held when start arrives only counts after a release and a new press.
    assign press = bus.button & ~button_q;
    assign tick  = (presc_q == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            delay_q  <= '0;
            ms_q     <= '0;
            rt_ms_q  <= '0;
            button_q <= 1'b0;
            led_q    <= 1'b0;
            rv_q     <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            delay_q  <= delay_d;
            ms_q     <= ms_d;
            rt_ms_q  <= rt_ms_d;
            button_q <= bus.button;
            led_q    <= led_d;
            rv_q     <= rv_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        delay_d = delay_q;
        ms_d    = ms_q;
        rt_ms_d = rt_ms_q;
        led_d   = led_q;
        rv_d    = rv_q;
        fs_d    = fs_q;
        to_d    = to_q;

        case (state_q)
            IDLE, RESULT: begin
                // start outranks a same-cycle press; presses are ignored here
                if (bus.start) begin
                    state_d = WAIT;
                    delay_d = MIN_D + {4'd0, bus.rand_in};
                    presc_d = '0;
                    rt_ms_d = '0;
                    rv_d    = 1'b0;
                    fs_d    = 1'b0;
                    to_d    = 1'b0;
                end
            end
            WAIT: begin
                if (press) begin
                    state_d = RESULT;
                    fs_d    = 1'b1;
                end else if (tick) begin
                    if (delay_q == 14'd1) begin
                        state_d = GO;
                        led_d   = 1'b1;
                        ms_d    = '0;
                        presc_d = '0;
                    end else begin
                        delay_d = delay_q - 14'd1;
                    end
                end
            end
            GO: begin
                if (press) begin
                    state_d = RESULT;
                    rt_ms_d = ms_q;
                    rv_d    = 1'b1;
                    led_d   = 1'b0;
                end else if (tick) begin
                    if (ms_q == MAX_M1) begin
                        state_d = RESULT;
                        rt_ms_d = MAX_RT;
                        to_d    = 1'b1;
                        led_d   = 1'b0;
                    end else begin
                        ms_d = ms_q + 14'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.led_on      = led_q;
    assign bus.busy        = (state_q == WAIT) || (state_q == GO);
    assign bus.rt_ms       = rt_ms_q;
    assign bus.rt_valid    = rv_q;
    assign bus.false_start = fs_q;
    assign bus.timeout     = to_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
module tb_reaction_sequencer;

    localparam int TPM  = 4;
    localparam int MIN  = 2;
    localparam int MAXR = 3;
    localparam int NONE = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reaction_sequencer_if bus();

    reaction_sequencer #(
        .TICKS_PER_MS(TPM),
        .MIN_DELAY_MS(MIN),
        .MAX_RT_MS(MAXR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // kind: 0 = reaction measured, 1 = false start, 2 = timeout
    typedef struct {
        int kind;
        int rt;
        int cyc;
    } res_t;

    res_t res_q[$];
    int   led_q[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Outcome from the game rules: W = (MIN + r) ms of waiting, press seen in
    // cycle j (counted from the first WAIT cycle), result one edge later.
    function automatic res_t model(input int r, input int j, input int e0);
        res_t x;
        int   w;
        w = (MIN + r) * TPM;
        if (j < w) begin
            x.kind = 1; x.rt = 0; x.cyc = e0 + j + 1;
        end else if (j - w < MAXR * TPM) begin
            x.kind = 0; x.rt = (j - w) / TPM; x.cyc = e0 + j + 1;
        end else begin
            x.kind = 2; x.rt = MAXR; x.cyc = e0 + w + MAXR * TPM;
        end
        return x;
    endfunction

    task automatic idle(input int n, input bit final_btn);
        for (int i = 0; i < n; i++) begin
            bus.start   = 1'b0;
            bus.button  = (i == n - 1) ? final_btn : 1'($urandom);
            bus.rand_in = 10'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Called in the cycle that carries the start request.
    task automatic trial(input int r, input int j, input bit pre_button,
                         input bit hold_start, input int rst_at);
        int   w;
        int   e0;
        int   last;
        res_t x;
        w  = (MIN + r) * TPM;
        e0 = cyc + 1;
        x  = model(r, j, e0);
        bus.start   = 1'b1;
        bus.rand_in = 10'(r);
        bus.button  = pre_button;
        if (rst_at < 0) res_q.push_back(x);
        if (j >= w && (rst_at < 0 || rst_at >= w)) led_q.push_back(e0 + w);
        last = (rst_at >= 0) ? rst_at : x.cyc - e0 - 1;
        @(posedge clk); #1;
        check("wait_busy", int'(bus.busy), 1);
        check("wait_flags", int'({bus.rt_valid, bus.false_start, bus.timeout}), 0);
        check("wait_led", int'(bus.led_on), 0);
        check("wait_rt_ms", int'(bus.rt_ms), 0);
        bus.start   = hold_start;
        bus.rand_in = 10'($urandom);
        for (int t = 0; t <= last; t++) begin
            bus.button = (t >= j);
            if (t == rst_at) rst = 1'b1;
            @(posedge clk); #1;
        end
        if (rst_at >= 0) begin
            check("rst_led", int'(bus.led_on), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_flags", int'({bus.rt_valid, bus.false_start, bus.timeout}), 0);
            check("rst_rt_ms", int'(bus.rt_ms), 0);
            rst        = 1'b0;
            bus.start  = 1'b0;
            bus.button = 1'b0;
        end else if (!hold_start) begin
            bus.start  = 1'b0;
            bus.button = 1'b0;
        end
    endtask

    // Monitor: pops expectations whenever an outcome flag or the LED rises.
    initial begin
        logic prev_any;
        logic prev_led;
        logic any;
        res_t e;
        int   ef;
        int   lc;
        prev_any = 1'b0;
        prev_led = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_any = 1'b0;
                prev_led = 1'b0;
            end else begin
                any = bus.rt_valid | bus.false_start | bus.timeout;
                if (any && !prev_any) begin
                    check("result_expected", int'(res_q.size() > 0), 1);
                    if (res_q.size() > 0) begin
                        e  = res_q.pop_front();
                        ef = (e.kind == 0) ? 4 : (e.kind == 1) ? 2 : 1;
                        check("result_cycle", cyc, e.cyc);
                        check("result_flags", int'({bus.rt_valid, bus.false_start, bus.timeout}), ef);
                        check("result_rt_ms", int'(bus.rt_ms), e.rt);
                        check("result_led", int'(bus.led_on), 0);
                        check("result_busy", int'(bus.busy), 0);
                    end
                end
                if (bus.led_on && !prev_led) begin
                    check("led_expected", int'(led_q.size() > 0), 1);
                    if (led_q.size() > 0) begin
                        lc = led_q.pop_front();
                        check("led_rise_cycle", cyc, lc);
                    end
                end
                prev_any = any;
                prev_led = bus.led_on;
            end
        end
    end

    initial begin
        int r;
        int w;
        int cat;
        int j;
        bit pre;
        bus.start   = 1'b0;
        bus.button  = 1'b0;
        bus.rand_in = '0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", int'(bus.led_on), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_flags", int'({bus.rt_valid, bus.false_start, bus.timeout}), 0);
        check("reset_rt_ms", int'(bus.rt_ms), 0);
        rst = 1'b0;
        idle(3, 1'b0);

        trial(3, 30, 1'b0, 1'b0, -1);            // normal: GO cycle 10 -> 2 ms
        idle(4, 1'b0);
        trial(1, 5, 1'b0, 1'b0, -1);             // false start in WAIT cycle 5
        idle(4, 1'b1);
        trial(5, 28, 1'b1, 1'b0, -1);            // held button, press at GO cycle 0
        idle(3, 1'b0);
        trial(0, NONE, 1'b0, 1'b0, -1);          // timeout
        idle(2, 1'b0);
        trial(2, NONE, 1'b0, 1'b1, -1);          // start held through WAIT/GO
        trial(4, 29, 1'b1, 1'b0, -1);            // start+press in RESULT
        idle(3, 1'b0);
        trial(0, NONE, 1'b0, 1'b0, 11);          // reset in GO cycle 3
        idle(3, 1'b0);
        trial(0, 0, 1'b0, 1'b0, -1);             // press in first WAIT cycle
        idle(2, 1'b0);
        trial(1, 11, 1'b0, 1'b0, -1);            // press in last WAIT cycle
        idle(2, 1'b0);
        trial(1, 23, 1'b0, 1'b0, -1);            // press in last GO cycle
        idle(2, 1'b0);
        trial(1023, 4107, 1'b0, 1'b0, -1);       // largest LFSR sample
        idle(2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            r   = int'($urandom_range(0, 15));
            w   = (MIN + r) * TPM;
            cat = int'($urandom_range(0, 2));
            if (cat == 0)      j = int'($urandom_range(0, w - 1));
            else if (cat == 1) j = w + int'($urandom_range(0, MAXR * TPM - 1));
            else               j = NONE;
            pre = (cat != 0) ? 1'($urandom) : 1'b0;
            idle(int'($urandom_range(1, 5)), pre);
            trial(r, j, pre, 1'b0, -1);
        end

        idle(6, 1'b0);
        check("results_drained", res_q.size(), 0);
        check("leds_drained", led_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
